tglgen: RTL

TGLGEN -- requirements
Module: tglgen

---
 rtl/tglgen_pkg.sv | 19 +
 rtl/tglgen_cnt.sv | 62 ++++++
 rtl/tglgen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tglgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tglgen_pkg
// Description : Shared definitions for the toggle generator: FSM state
//               encodings and the hold-counter width/type.
// Revision    : 1.0 - initial release
// ============================================================================
package tglgen_pkg;

    // Hold counter is sized for HOLD_CYC up to 255.
    localparam int unsigned HOLD_W = 8;
    typedef logic [HOLD_W-1:0] hold_t;

    // FSM state encodings.
    localparam logic [0:0] ST_IDLE = 1'b0;  // tgl_out stable
    localparam logic [0:0] ST_HOLD = 1'b1;  // hold counter running

endpackage : tglgen_pkg
`default_nettype wire

// File: rtl/tglgen_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tglgen_cnt
// Description : Saturating up/down counter of pending toggle events.
//               Simultaneous inc and dec leave the count unchanged; inc at
//               the maximum value is ignored, and so is dec at zero.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               inc   - add one event
//               dec   - remove one event
//               clr   - synchronous clear, overrides inc/dec
//               cnt   - current count (direct from flops)
//               sat   - count is at its maximum value
// Revision    : 1.0 - initial release
// ============================================================================
module tglgen_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (inc && !dec) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (dec && !inc) begin
            if (cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == CNT_MAX);

endmodule : tglgen_cnt
`default_nettype wire

// File: rtl/tglgen.sv
`default_nettype none
// ============================================================================
// Module      : tglgen
// Description : Converts single-cycle event pulses into inversions of a level
//               output, each level held at least HOLD_CYC cycles, so that a
//               downstream edge detector yields one pulse per accepted event.
//               Events arriving during a hold are queued in a saturating
//               counter; events lost at saturation set a sticky flag.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               pls_in  - event pulse, one event per cycle high
//               clr     - synchronous clear of pending events and overflow
//               tgl_out - level output, inverts once per accepted event
//               busy    - events pending or hold in progress
//               pend    - accepted events not yet issued
//               ovf     - sticky: at least one event was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module tglgen
    import tglgen_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pls_in,
    input  logic             clr,
    output logic             tgl_out,
    output logic             busy,
    output logic [CNT_W-1:0] pend,
    output logic             ovf
);

    localparam hold_t HOLD_LOAD = hold_t'(HOLD_CYC - 1);
    localparam hold_t HOLD_ZERO = '0;
    localparam hold_t HOLD_ONE  = hold_t'(1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    hold_t            hold_q;
    hold_t            hold_d;
    logic             tgl_q;
    logic             tgl_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [CNT_W-1:0] cnt_w;
    logic             sat_w;
    logic             pend_nz_w;
    logic             inv_w;
    logic             direct_w;
    logic             inc_w;
    logic             dec_w;
    logic             drop_w;

    assign pend_nz_w = (cnt_w != '0);

    // An event arriving in IDLE with nothing queued is issued straight away
    // and never enters the pending counter.
    assign direct_w = (state_q == ST_IDLE) && !pend_nz_w && pls_in;
    assign inc_w    = pls_in && !direct_w;
    // Every inversion other than a direct one consumes a queued event.
    assign dec_w    = inv_w && pend_nz_w;
    // Saturation implies pend!=0, so a direct issue can never be a drop.
    assign drop_w   = pls_in && !clr && sat_w && !dec_w;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        inv_w   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_nz_w || pls_in) begin
                    inv_w   = 1'b1;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q != HOLD_ZERO) begin
                    hold_d = hold_q - HOLD_ONE;
                end else if (pend_nz_w) begin
                    inv_w  = 1'b1;
                    hold_d = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tgl_d = inv_w ? ~tgl_q : tgl_q;
        ovf_d = ovf_q | drop_w;

        // Clear wins over everything but deliberately keeps the output
        // level so the downstream edge detector sees no spurious edge.
        if (clr) begin
            state_d = ST_IDLE;
            hold_d  = HOLD_ZERO;
            tgl_d   = tgl_q;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= HOLD_ZERO;
            tgl_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tgl_q   <= tgl_d;
            ovf_q   <= ovf_d;
        end
    end

    tglgen_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_w),
        .dec   (dec_w),
        .clr   (clr),
        .cnt   (cnt_w),
        .sat   (sat_w)
    );

    assign tgl_out = tgl_q;
    assign pend    = cnt_w;
    assign ovf     = ovf_q;
    assign busy    = (state_q == ST_HOLD) || pend_nz_w;

endmodule : tglgen
`default_nettype wire
